// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: register-index width, base opcodes and the
// hazard sequencer FSM state encoding.
package riscv_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } hz_state_e;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  function automatic logic is_x0(input logic [REG_W-1:0] idx);
    return idx == {REG_W{1'b0}};
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard-unit bundle between pipeline (master) and hazard sequencer (slave).
// stall_count exists only when STALL_COUNT_EN is defined.
interface hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  import riscv_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             stall;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             freeze;
  logic             mem_err;
`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stall_count;
`endif

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, mem_req, mem_ready,
`ifdef STALL_COUNT_EN
    input  stall_count,
`endif
    input  stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, mem_req, mem_ready,
`ifdef STALL_COUNT_EN
    output stall_count,
`endif
    output stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_err
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX whose rd feeds the ID instruction.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  output logic             hazard
);

  assign hazard = ex_memread && !is_x0(ex_rd) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall, branch flush, memory-wait freeze
// with timeout. Define STALL_COUNT_EN to build the saturating stall counter.
module hazard_sequencer
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_sequencer_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT = (WAIT_W + 1)'(MEM_TIMEOUT);

  hz_state_e         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_inc;
  logic              mem_err;
  logic              load_use;
  logic              frozen;
  logic              stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze;

  load_use_detect u_load_use (
    .id_rs1     (hz.id_rs1),
    .id_rs2     (hz.id_rs2),
    .ex_rd      (hz.ex_rd),
    .ex_memread (hz.ex_memread),
    .hazard     (load_use)
  );

  assign wait_inc = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};

  // FSM: an access that misses its first cycle is timed; timeout locks into ERR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz.mem_req && !hz.mem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (hz.mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_inc >= TIMEOUT) begin
            state    <= ST_ERR;
            mem_err  <= 1'b1;
            wait_cnt <= wait_inc[WAIT_W-1:0];
          end else begin
            wait_cnt <= wait_inc[WAIT_W-1:0];
          end
        end
        ST_ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state   <= ST_ERR;
          mem_err <= 1'b1;
        end
      endcase
    end
  end

  // Mealy outputs; priority is reset, freeze, branch flush, then load-use.
  always_comb begin
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    freeze     = 1'b0;
    case (state)
      ST_RUN:      frozen = hz.mem_req && !hz.mem_ready;
      ST_MEM_WAIT: frozen = !hz.mem_ready;
      default:     frozen = 1'b1;
    endcase
    if (reset) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (frozen) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (hz.ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      stall      = 1'b0;
    end
  end

  assign hz.stall      = stall;
  assign hz.pc_write   = pc_write;
  assign hz.ifid_write = ifid_write;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.freeze     = freeze;
  assign hz.mem_err    = mem_err;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stall_count;

  // Saturating count of cycles lost to a bubble or a freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if ((stall || freeze) && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end else begin
      stall_count <= stall_count;
    end
  end

  assign hz.stall_count = stall_count;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (MEM_TIMEOUT=4, CNT_W=3).
module tb_hazard_sequencer;
  import riscv_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  hazard_sequencer_if #(.CNT_W(3)) hz ();

  hazard_sequencer #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_err}
  function automatic logic [6:0] outs();
    return {hz.stall, hz.pc_write, hz.ifid_write, hz.ifid_flush,
            hz.idex_flush, hz.freeze, hz.mem_err};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic memrd, input logic br, input logic req, input logic rdy);
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.ex_rd           = rd;
    hz.ex_memread      = memrd;
    hz.ex_branch_taken = br;
    hz.mem_req         = req;
    hz.mem_ready       = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (outs() !== 7'b1000000) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs(), 7'b1000000); end
    n_checks++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_RUN); end
    @(negedge clk);
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL idle_outs: got %b want %b", outs(), 7'b0110000); end
  endtask

  task automatic test_load_use();
    @(negedge clk); drive(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b1000000) begin n_fail++; $display("FAIL lu_rs2: got %b want %b", outs(), 7'b1000000); end
    @(negedge clk); drive(5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL lu_after_bubble: got %b want %b", outs(), 7'b0110000); end
    @(negedge clk); drive(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b1000000) begin n_fail++; $display("FAIL lu_rs1: got %b want %b", outs(), 7'b1000000); end
    @(negedge clk); drive(5'd7, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL lu_nomatch: got %b want %b", outs(), 7'b0110000); end
    @(negedge clk); drive(5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL lu_not_load: got %b want %b", outs(), 7'b0110000); end
  endtask

  task automatic test_x0();
    @(negedge clk); drive(5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL x0_no_stall: got %b want %b", outs(), 7'b0110000); end
  endtask

  task automatic test_branch();
    @(negedge clk); drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b0111100) begin n_fail++; $display("FAIL branch_over_lu: got %b want %b", outs(), 7'b0111100); end
  endtask

  task automatic test_mem_wait();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); #1;
      n_checks++;
      if (outs() !== 7'b0000010) begin n_fail++; $display("FAIL mw_freeze_c%0d: got %b want %b", c, outs(), 7'b0000010); end
    end
    n_checks++;
    if (dut.state !== ST_MEM_WAIT) begin n_fail++; $display("FAIL mw_state: got %0d want %0d", dut.state, ST_MEM_WAIT); end
    @(negedge clk); drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1); #1;
    n_checks++;
    if (outs() !== 7'b0111100) begin n_fail++; $display("FAIL mw_ready_c4: got %b want %b", outs(), 7'b0111100); end
    @(negedge clk); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL mw_back_run: got %0d want %0d", dut.state, ST_RUN); end
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL mw_idle: got %b want %b", outs(), 7'b0110000); end
  endtask

  task automatic test_one_cycle();
    @(negedge clk); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL one_cycle_outs: got %b want %b", outs(), 7'b0110000); end
    @(negedge clk); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL one_cycle_state: got %0d want %0d", dut.state, ST_RUN); end
  endtask

  task automatic test_timeout();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      n_checks++;
      if (outs() !== 7'b0000010) begin n_fail++; $display("FAIL to_wait_c%0d: got %b want %b", c, outs(), 7'b0000010); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); #1;
      n_checks++;
      if (outs() !== 7'b0000011) begin n_fail++; $display("FAIL to_err_c%0d: got %b want %b", c, outs(), 7'b0000011); end
    end
    n_checks++;
    if (dut.state !== ST_ERR) begin n_fail++; $display("FAIL to_state_err: got %0d want %0d", dut.state, ST_ERR); end
    #1; reset = 1'b1; #1;
    n_checks++;
    if (outs() !== 7'b1000000) begin n_fail++; $display("FAIL to_reset_outs: got %b want %b", outs(), 7'b1000000); end
    n_checks++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL to_reset_state: got %0d want %0d", dut.state, ST_RUN); end
    @(negedge clk); reset = 1'b0; drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL to_after_reset: got %b want %b", outs(), 7'b0110000); end
  endtask

  task automatic test_reset_mem_wait();
    @(negedge clk); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    n_checks++;
    if (outs() !== 7'b0000010) begin n_fail++; $display("FAIL rmw_frozen: got %b want %b", outs(), 7'b0000010); end
    #1; reset = 1'b1; #1;
    n_checks++;
    if (outs() !== 7'b1000000) begin n_fail++; $display("FAIL rmw_reset_outs: got %b want %b", outs(), 7'b1000000); end
    @(negedge clk); reset = 1'b0; drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    n_checks++;
    if (outs() !== 7'b0110000) begin n_fail++; $display("FAIL rmw_no_freeze: got %b want %b", outs(), 7'b0110000); end
    n_checks++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL rmw_state: got %0d want %0d", dut.state, ST_RUN); end
  endtask

  task automatic test_stall_count();
`ifdef STALL_COUNT_EN
    @(negedge clk); reset = 1'b1; #1;
    n_checks++;
    if (hz.stall_count !== 3'd0) begin n_fail++; $display("FAIL sc_reset: got %0d want %0d", hz.stall_count, 3'd0); end
    reset = 1'b0;
    drive(5'd0, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (hz.stall_count !== 3'd4) begin n_fail++; $display("FAIL sc_mid: got %0d want %0d", hz.stall_count, 3'd4); end
    repeat (5) @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (hz.stall_count !== 3'd7) begin n_fail++; $display("FAIL sc_saturate: got %0d want %0d", hz.stall_count, 3'd7); end
    @(negedge clk);
    n_checks++;
    if (hz.stall_count !== 3'd7) begin n_fail++; $display("FAIL sc_hold: got %0d want %0d", hz.stall_count, 3'd7); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_one_cycle();
    test_timeout();
    test_reset_mem_wait();
    test_stall_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16: maximum consecutive wait cycles tolerated on one data-memory access.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the stall performance counter.
REQ-003 The block SHALL have port clk  input  1  single system clock, all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port id_rs1  input  5  rs1 index of the instruction in ID.
REQ-006 The block SHALL have port id_rs2  input  5  rs2 index of the instruction in ID.
REQ-007 The block SHALL have port ex_rd  input  5  rd index of the instruction in EX.
REQ-008 The block SHALL have port ex_memread  input  1  EX instruction is a load.
REQ-009 The block SHALL have port ex_branch_taken  input  1  branch or jalr resolved taken in EX.
REQ-010 The block SHALL have port mem_req  input  1  MEM stage is performing a load or store.
REQ-011 The block SHALL have port mem_ready  input  1  data memory completes the current access this cycle.
REQ-012 The block SHALL have port stall  output  1  bubble request to the control unit, which zeroes all control signals.
REQ-013 The block SHALL have port pc_write  output  1  PC register enable.
REQ-014 The block SHALL have port ifid_write  output  1  IF/ID register enable.
REQ-015 The block SHALL have port ifid_flush  output  1  clears IF/ID to a NOP.
REQ-016 The block SHALL have port idex_flush  output  1  clears ID/EX to a NOP.
REQ-017 The block SHALL have port freeze  output  1  holds every pipeline register.
REQ-018 The block SHALL have port mem_err  output  1  sticky memory-timeout flag.
REQ-019 The block SHALL have port stall_count  output  CNT_W  stalled-cycle count; present only under STALL_COUNT_EN.

Function
REQ-020 The block SHALL implement an FSM with states RUN, MEM_WAIT and ERR, plus a wait counter of width clog2(MEM_TIMEOUT+1).
REQ-021 The block SHALL compute all outputs combinationally in the same cycle from the current state and inputs (Mealy).
REQ-022 The load-use hazard SHALL be defined as: ex_memread=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2.
REQ-023 On a load-use hazard in RUN, the block SHALL drive stall=1, pc_write=0 and ifid_write=0 for exactly that cycle; the bubble removes the hazard on the following cycle.
REQ-024 When ex_branch_taken=1 in RUN, the block SHALL drive ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1 and stall=0.
REQ-025 Branch flush SHALL take priority over load-use when both occur in the same cycle.
REQ-026 Freeze SHALL take priority over both branch flush and load-use; these are re-evaluated on the first unfrozen cycle, because pipeline contents are unchanged.
REQ-027 In RUN with mem_req=1 and mem_ready=0, the block SHALL drive freeze=1, pc_write=0, ifid_write=0, stall=0 and both flushes=0, move to MEM_WAIT, and load the wait counter with 1.
REQ-028 A one-cycle access (mem_req=1, mem_ready=1 in RUN) SHALL cause no freeze.
REQ-029 In MEM_WAIT, freeze SHALL stay at 1 until mem_ready=1; in the mem_ready cycle freeze=0 and the state returns to RUN.
REQ-030 In MEM_WAIT, the wait counter SHALL increment each cycle with mem_ready=0; on reaching MEM_TIMEOUT it SHALL move to ERR.
REQ-031 In ERR, the block SHALL set mem_err=1 and hold freeze=1 until reset; ERR SHALL have no exit except reset.
REQ-032 With no hazard, freeze or flush active, the block SHALL drive pc_write=1, ifid_write=1, and all other outputs 0.

Reset
REQ-033 Asserting reset SHALL immediately force state=RUN, wait counter=0, mem_err=0 and stall_count=0.
REQ-034 While reset=1, the block SHALL drive pc_write=0, ifid_write=0, stall=1, flushes=0 and freeze=0.
REQ-035 Reset asserted during MEM_WAIT or ERR SHALL abandon the access without any further freeze.

Configuration
REQ-036 With macro STALL_COUNT_EN defined, the block SHALL increment stall_count each cycle in which stall|freeze=1 and saturate at all-ones.
REQ-037 With STALL_COUNT_EN undefined, port stall_count and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-038 The FSM state encoding, the register-index width (5) and the opcode constants SHALL live in the shared package riscv_pkg.
REQ-039 The load-use comparator SHALL be the sub-module load_use_detect (combinational).

Verification
REQ-040 The bench SHALL cover: ex_memread=1, ex_rd=5, id_rs2=5 -> stall=1, pc_write=0, ifid_write=0 for one cycle, then pc_write=1.
REQ-041 The bench SHALL cover: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall.
REQ-042 The bench SHALL cover: ex_branch_taken=1 together with a load-use hazard -> ifid_flush=idex_flush=1, stall=0, pc_write=1.
REQ-043 The bench SHALL cover: mem_req=1, mem_ready=0 for 3 cycles and then 1 -> freeze=1 for 3 cycles, 0 in the 4th cycle, state RUN.
REQ-044 The bench SHALL cover: mem_ready held at 0 with MEM_TIMEOUT=4 -> ERR after the 4th counted wait, mem_err=1 sticky, then reset -> mem_err=0, state RUN.
REQ-045 The bench SHALL cover, with STALL_COUNT_EN and CNT_W=3: 9 stalled cycles -> stall_count=7 (saturated).
